qtr_sensor_emulator: RTL and testbench

- Emulates one RC-discharge infrared reflectance sensor channel: the far end of the charge/release/time-discharge pin protocol used by the infrared line counter.
- The controller charges the pin, then releases it. The emulator holds the line high for a programmed decay time, chosen by the commanded surface (black or white), then pulls it low.
- Used for hardware-in-loop and bench stimulation of the line-detection path without a physical sensor.

---
 rtl/qtr_emu_pkg.sv | 20 ++
 rtl/qtr_emu_lfsr.sv | 31 +++
 rtl/qtr_sensor_emulator.sv | 167 ++++++++++++++++
 tb/tb_qtr_sensor_emulator.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/qtr_emu_pkg.sv
// qtr_emu_pkg
//   Shared definitions for the RC-discharge reflectance sensor emulator:
//   FSM state encoding, default timing constants and the jitter LFSR
//   seed/tap constants (the LFSR is only built with QTR_EMU_JITTER_EN).
package qtr_emu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHARGE = 2'd1,
    DECAY  = 2'd2
  } qtr_state_e;

  localparam int DEF_CHARGE_MIN = 10;
  localparam int DEF_TIMEOUT    = 32768;

  // x^8 + x^6 + x^5 + x^4 + 1, a maximal-length polynomial (taps on bits 7,5,4,3)
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/qtr_emu_lfsr.sv
// qtr_emu_lfsr
//   8-bit Fibonacci LFSR that steps once per advance strobe. It supplies
//   the pseudo-random jitter added to the emulated decay time.
//   The module only exists in builds with QTR_EMU_JITTER_EN defined, so the
//   deterministic build carries no orphan module.
// Ports:
//   clock    system clock
//   reset    asynchronous active-low reset (loads LFSR_SEED)
//   advance  step the register by one position
//   value    current LFSR contents
`ifdef QTR_EMU_JITTER_EN
module qtr_emu_lfsr
  import qtr_emu_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       advance,
  output logic [7:0] value
);

  // Shift left, feeding back the XOR of the tapped bits into bit 0.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      value <= LFSR_SEED;
    end else if (advance) begin
      value <= {value[6:0], ^(value & LFSR_TAPS)};
    end
  end

endmodule
`endif

// File: rtl/qtr_sensor_emulator.sv
// qtr_sensor_emulator
//   Far end of the charge / release / timed-discharge sensor pin protocol.
//   After the controller has charged the pin for at least CHARGE_MIN cycles
//   and released it, the emulator holds the line high for a decay time
//   chosen by the commanded surface, then pulls it low and counts the read.
//   Optional build macro QTR_EMU_JITTER_EN adds 0..15 cycles of LFSR jitter
//   to each latched decay time; without it timing is fully deterministic.
// Ports:
//   clock         system clock
//   reset         asynchronous active-low reset
//   driveEnable   1 = controller drives the pin, 0 = pin released
//   driveSignal   level driven by the controller while driveEnable=1
//   surfaceBlack  1 = black surface, 0 = white surface
//   decayBlack    high time in cycles for black
//   decayWhite    high time in cycles for white
//   sensorOut     line level presented to the controller
//   busy          high while charging or decaying
//   shortCharge   sticky: a release arrived before CHARGE_MIN charge cycles
//   readCount     completed valid reads, wraps 255 -> 0
module qtr_sensor_emulator
  import qtr_emu_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int CHARGE_MIN = DEF_CHARGE_MIN,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             driveEnable,
  input  logic             driveSignal,
  input  logic             surfaceBlack,
  input  logic [WIDTH-1:0] decayBlack,
  input  logic [WIDTH-1:0] decayWhite,
  output logic             sensorOut,
  output logic             busy,
  output logic             shortCharge,
  output logic [7:0]       readCount
);

  localparam int CW = $clog2(CHARGE_MIN + 1);
  localparam logic [CW-1:0]  CHARGE_DONE = CW'(CHARGE_MIN);
  localparam logic [WIDTH:0] DECAY_CAP   = (WIDTH + 1)'(TIMEOUT - 1);

  qtr_state_e       state, stateNext;
  logic [CW-1:0]    chargeCnt, chargeNext;
  logic [WIDTH-1:0] decayCnt, decayNext;
  logic             sensorNext, shortNext;
  logic [7:0]       countNext;
  logic             latchRead;
  logic [WIDTH-1:0] selDecay;
  logic [WIDTH:0]   sumN;
  logic [WIDTH-1:0] latchedN;

`ifdef QTR_EMU_JITTER_EN
  logic [7:0] lfsrValue;

  qtr_emu_lfsr u_lfsr (
    .clock   (clock),
    .reset   (reset),
    .advance (latchRead),
    .value   (lfsrValue)
  );
`endif

  // Decay time that would be latched if the pin were released this cycle.
  // The sum is one bit wider so jitter cannot wrap before the cap is applied.
  always_comb begin
    selDecay = surfaceBlack ? decayBlack : decayWhite;
`ifdef QTR_EMU_JITTER_EN
    sumN = {1'b0, selDecay} + {{(WIDTH - 3){1'b0}}, lfsrValue[3:0]};
`else
    sumN = {1'b0, selDecay};
`endif
    latchedN = (sumN > DECAY_CAP) ? DECAY_CAP[WIDTH-1:0] : sumN[WIDTH-1:0];
  end

  // Next-state and next-output logic. Outputs are computed here and
  // registered below so every output is a flop.
  always_comb begin
    stateNext  = state;
    chargeNext = chargeCnt;
    decayNext  = decayCnt;
    sensorNext = sensorOut;
    shortNext  = shortCharge;
    countNext  = readCount;
    latchRead  = 1'b0;
    case (state)
      IDLE: begin
        sensorNext = 1'b0;
        if (driveEnable && driveSignal) begin
          stateNext  = CHARGE;
          chargeNext = CW'(1);
        end
      end
      CHARGE: begin
        sensorNext = 1'b0;
        if (driveEnable) begin
          if (driveSignal) begin
            if (chargeCnt < CHARGE_DONE) chargeNext = chargeCnt + CW'(1);
          end else begin
            stateNext = IDLE;
          end
        end else if (chargeCnt >= CHARGE_DONE) begin
          latchRead = 1'b1;
          if (latchedN == '0) begin
            stateNext = IDLE;
            countNext = readCount + 8'd1;
          end else begin
            // Line rises on the edge that samples the release; decayCnt
            // holds the number of high cycles still to be shown.
            stateNext  = DECAY;
            decayNext  = latchedN;
            sensorNext = 1'b1;
          end
        end else begin
          stateNext = IDLE;
          shortNext = 1'b1;
        end
      end
      DECAY: begin
        if (driveEnable) begin
          sensorNext = 1'b0;
          decayNext  = '0;
          if (driveSignal) begin
            stateNext  = CHARGE;
            chargeNext = CW'(1);
          end else begin
            stateNext = IDLE;
          end
        end else begin
          decayNext = decayCnt - WIDTH'(1);
          if (decayCnt <= WIDTH'(1)) begin
            sensorNext = 1'b0;
            countNext  = readCount + 8'd1;
            stateNext  = IDLE;
          end
        end
      end
      default: begin
        stateNext  = IDLE;
        sensorNext = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops sensorOut immediately.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      chargeCnt   <= '0;
      decayCnt    <= '0;
      sensorOut   <= 1'b0;
      busy        <= 1'b0;
      shortCharge <= 1'b0;
      readCount   <= 8'd0;
    end else begin
      state       <= stateNext;
      chargeCnt   <= chargeNext;
      decayCnt    <= decayNext;
      sensorOut   <= sensorNext;
      busy        <= (stateNext != IDLE);
      shortCharge <= shortNext;
      readCount   <= countNext;
    end
  end

endmodule

// File: tb/tb_qtr_sensor_emulator.sv
// tb_qtr_sensor_emulator
//   Directed bench for qtr_sensor_emulator. A transaction-level model tracks
//   charge length and remaining high time and is compared against the DUT on
//   every falling edge; literal pulse widths and counts pin the model.
module tb_qtr_sensor_emulator;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        driveEnable = 1'b0;
  logic        driveSignal = 1'b0;
  logic        surfaceBlack = 1'b0;
  logic [15:0] decayBlack = 16'd0;
  logic [15:0] decayWhite = 16'd0;
  logic        sensorOut;
  logic        busy;
  logic        shortCharge;
  logic [7:0]  readCount;

  int vectors = 0;
  int miscompares = 0;

  qtr_sensor_emulator dut (
    .clock        (clock),
    .reset        (reset),
    .driveEnable  (driveEnable),
    .driveSignal  (driveSignal),
    .surfaceBlack (surfaceBlack),
    .decayBlack   (decayBlack),
    .decayWhite   (decayWhite),
    .sensorOut    (sensorOut),
    .busy         (busy),
    .shortCharge  (shortCharge),
    .readCount    (readCount)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Pulse width check; jitter builds accept any width in [n, min(n+15, cap)].
  task automatic checkWidth(input string name, input int actual, input int n);
`ifdef QTR_EMU_JITTER_EN
    int hi;
    hi = (n + 15 > 32767) ? 32767 : n + 15;
    vectors++;
    if (actual < n || actual > hi) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, n, hi);
    end
`else
    checkOutput(name, actual, n);
`endif
  endtask

  // Transaction-level model: phase 0 idle, 1 charging, 2 line high.
  int phase = 0;
  int chargeLen = 0;
  int highLeft = 0;
  int expCount = 0;
  bit expShort = 1'b0;
  int modelLfsr = 8'hA5;

  always @(posedge clock or negedge reset) begin
    int n;
    if (!reset) begin
      phase = 0; chargeLen = 0; highLeft = 0; expCount = 0; expShort = 1'b0;
      modelLfsr = 8'hA5;
    end else begin
      if (phase == 0) begin
        if (driveEnable && driveSignal) begin phase = 1; chargeLen = 1; end
      end else if (phase == 1) begin
        if (driveEnable) begin
          if (driveSignal) chargeLen++;
          else phase = 0;
        end else if (chargeLen >= 10) begin
          n = surfaceBlack ? int'(decayBlack) : int'(decayWhite);
`ifdef QTR_EMU_JITTER_EN
          n = n + (modelLfsr % 16);
          modelLfsr = ((modelLfsr * 2) % 256) |
                      (((modelLfsr >> 7) ^ (modelLfsr >> 5) ^ (modelLfsr >> 4) ^ (modelLfsr >> 3)) & 1);
`endif
          if (n > 32767) n = 32767;
          if (n == 0) begin expCount = (expCount + 1) % 256; phase = 0; end
          else begin highLeft = n; phase = 2; end
        end else begin
          expShort = 1'b1; phase = 0;
        end
      end else begin
        if (driveEnable) begin
          highLeft = 0;
          if (driveSignal) begin phase = 1; chargeLen = 1; end
          else phase = 0;
        end else begin
          highLeft--;
          if (highLeft == 0) begin expCount = (expCount + 1) % 256; phase = 0; end
        end
      end
    end
  end

  // Every falling edge the registered outputs must match the model.
  always @(negedge clock) begin
    checkOutput("sensorOut", int'(sensorOut), (phase == 2) ? 1 : 0);
    checkOutput("busy", int'(busy), (phase != 0) ? 1 : 0);
    checkOutput("shortCharge", int'(shortCharge), int'(expShort));
    checkOutput("readCount", int'(readCount), expCount);
  end

  // Drive the pin inputs at a falling edge and hold them for some cycles.
  task automatic applyStimulus(input logic de, input logic ds, input logic sb, input int cycles);
    driveEnable  = de;
    driveSignal  = ds;
    surfaceBlack = sb;
    repeat (cycles) @(negedge clock);
  endtask

  // Release the pin and count high cycles until the emulator goes idle.
  task automatic measurePulse(input int toggleAt, output int width);
    bit done;
    done = 1'b0;
    width = 0;
    driveEnable = 1'b0;
    driveSignal = 1'b0;
    for (int c = 1; c <= 40000; c++) begin
      @(negedge clock);
      if (sensorOut) width++;
      if (c == toggleAt) surfaceBlack = ~surfaceBlack;
      if (!busy) begin done = 1'b1; break; end
    end
    if (!done) checkOutput("pulseTimeout", 0, 1);
  endtask

  task automatic doRead(input int charge, input logic sb, input int toggleAt, output int width);
    applyStimulus(1'b1, 1'b1, sb, charge);
    measurePulse(toggleAt, width);
  endtask

  initial begin
    int w;
    repeat (3) @(negedge clock);
    checkOutput("resetSensor", int'(sensorOut), 0);
    checkOutput("resetBusy", int'(busy), 0);
    checkOutput("resetShort", int'(shortCharge), 0);
    checkOutput("resetCount", int'(readCount), 0);
    reset = 1'b1;
    @(negedge clock);

    decayBlack = 16'd500;
    decayWhite = 16'd20;
    doRead(12, 1'b1, 0, w);
    checkWidth("blackWidth", w, 500);
    checkOutput("blackCount", int'(readCount), 1);
    checkOutput("blackBusyAfter", int'(busy), 0);

    doRead(12, 1'b0, 5, w);
    checkWidth("whiteWidthToggled", w, 20);
    checkOutput("whiteCount", int'(readCount), 2);

    doRead(5, 1'b1, 0, w);
    checkOutput("shortWidth", w, 0);
    checkOutput("shortFlag", int'(shortCharge), 1);
    checkOutput("shortCount", int'(readCount), 2);
    doRead(9, 1'b1, 0, w);
    checkOutput("nineWidth", w, 0);
    checkOutput("nineCount", int'(readCount), 2);
    doRead(10, 1'b0, 0, w);
    checkWidth("tenWidth", w, 20);
    checkOutput("tenCount", int'(readCount), 3);
    checkOutput("shortSticky", int'(shortCharge), 1);

    decayBlack = 16'd40000;
    doRead(12, 1'b1, 0, w);
    checkWidth("clampWidth", w, 32767);
    checkOutput("clampCount", int'(readCount), 4);

    decayBlack = 16'd0;
    doRead(12, 1'b1, 0, w);
    checkWidth("zeroWidth", w, 0);
    checkOutput("zeroCount", int'(readCount), 5);

    applyStimulus(1'b1, 1'b1, 1'b1, 3);
    applyStimulus(1'b1, 1'b0, 1'b1, 1);
    checkOutput("dischargeIdle", int'(busy), 0);
    checkOutput("dischargeCount", int'(readCount), 5);

    decayBlack = 16'd500;
    applyStimulus(1'b1, 1'b1, 1'b1, 12);
    applyStimulus(1'b0, 1'b0, 1'b1, 100);
    checkOutput("abortHighBefore", int'(sensorOut), 1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1);
    checkOutput("abortSensor", int'(sensorOut), 0);
    checkOutput("abortBusy", int'(busy), 1);
    checkOutput("abortCount", int'(readCount), 5);
    applyStimulus(1'b1, 1'b0, 1'b1, 1);
    checkOutput("abortIdle", int'(busy), 0);

    applyStimulus(1'b1, 1'b1, 1'b1, 12);
    applyStimulus(1'b0, 1'b0, 1'b1, 50);
    #2 reset = 1'b0;
    #1;
    checkOutput("midResetSensor", int'(sensorOut), 0);
    checkOutput("midResetCount", int'(readCount), 0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    decayWhite = 16'd1;
    for (int i = 0; i < 256; i++) begin
      doRead(10, 1'b0, 0, w);
      if (i == 254) checkOutput("count255", int'(readCount), 255);
    end
    checkOutput("countWrap", int'(readCount), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
